// File: rtl/noc_input_fifo_if.sv
// ---------------------------------------------------------------------------
// noc_input_fifo_if
// Bundles the flit handshake and head-of-queue signals of a router input
// port buffer.
//   RX, DRTS          upstream flit and its request-to-send
//   CTS               single-cycle clear-to-send back to upstream
//   read_en_N/E/W/S/L grants from the five local output arbiters (pop)
//   Data_out          head flit, first-word fall-through
//   empty, full       fill status
//   count             number of stored flits, 0..DEPTH
//   err_flags         sticky protocol error flags
// Modports:
//   slave  - the FIFO itself
//   master - the upstream sender and the downstream arbiters
// ---------------------------------------------------------------------------
interface noc_input_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  logic [DATA_WIDTH-1:0]    RX;
  logic                     DRTS;
  logic                     CTS;
  logic                     read_en_N;
  logic                     read_en_E;
  logic                     read_en_W;
  logic                     read_en_S;
  logic                     read_en_L;
  logic [DATA_WIDTH-1:0]    Data_out;
  logic                     empty;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic [1:0]               err_flags;

  modport slave (
    input  RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
    output CTS, Data_out, empty, full, count, err_flags
  );

  modport master (
    output RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
    input  CTS, Data_out, empty, full, count, err_flags
  );
endinterface

// File: rtl/noc_input_fifo.sv
// ---------------------------------------------------------------------------
// noc_input_fifo
// Router input-port buffer. Receives flits over the RTS/CTS handshake,
// stores them in a circular FIFO and presents the head flit to LBDR and the
// crossbar. The head is popped when any local output arbiter grants it.
// Ports:
//   clk      clock
//   rst      synchronous, active-high reset
//   fifo_if  noc_input_fifo_if.slave (RX/DRTS/CTS handshake, read grants,
//            Data_out, empty, full, count, err_flags)
// Build option:
//   FIFO_ERR_FLAGS_EN  when defined, err_flags holds sticky protocol errors
//                      ([0] grant while empty, [1] several grants at once);
//                      otherwise err_flags is tied to 2'b00.
// ---------------------------------------------------------------------------
module noc_input_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst,
  noc_input_fifo_if.slave  fifo_if
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  cts_q, cts_d;

  logic [4:0]            rd_vec;
  logic                  rd_any;
  logic                  full_w, empty_w;
  logic                  wr_en, pop;

  always_comb begin
    rd_vec  = {fifo_if.read_en_N, fifo_if.read_en_E, fifo_if.read_en_W,
               fifo_if.read_en_S, fifo_if.read_en_L};
    rd_any  = |rd_vec;
    full_w  = (count_q == DEPTH_C);
    empty_w = (count_q == '0);
    // CTS high blocks the write so one RTS never stores the same flit twice.
    wr_en   = fifo_if.DRTS & ~cts_q & ~full_w;
    pop     = rd_any & ~empty_w;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cts_d    = wr_en;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cts_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cts_q    <= cts_d;
    end
  end

  // Storage is cleared on reset so Data_out reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= fifo_if.RX;
    end
  end

  assign fifo_if.CTS      = cts_q;
  assign fifo_if.Data_out = mem_q[rd_ptr_q];
  assign fifo_if.empty    = empty_w;
  assign fifo_if.full     = full_w;
  assign fifo_if.count    = count_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic [1:0] err_q, err_d;
  logic       multi_rd;

  always_comb begin
    // Clearing the lowest set bit leaves something only if two or more are set.
    multi_rd = (rd_vec & (rd_vec - 5'd1)) != 5'd0;
    err_d    = err_q | {multi_rd, rd_any & empty_w};
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 2'b00;
    else     err_q <= err_d;
  end

  assign fifo_if.err_flags = err_q;
`else
  assign fifo_if.err_flags = 2'b00;
`endif

endmodule

// File: tb/tb_noc_input_fifo.sv
module tb_noc_input_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  noc_input_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  noc_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .fifo_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] model_q [$];

`ifdef FIFO_ERR_FLAGS_EN
  localparam logic [1:0] ERR_EMPTY = 2'b01;
  localparam logic [1:0] ERR_BOTH  = 2'b11;
`else
  localparam logic [1:0] ERR_EMPTY = 2'b00;
  localparam logic [1:0] ERR_BOTH  = 2'b00;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_flit(input logic [DW-1:0] data);
    logic seen;
    seen = 1'b0;
    bus.DRTS = 1'b1;
    bus.RX   = data;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      seen = bus.CTS;
    end
    check("cts_seen", seen, 1'b1);
    bus.DRTS = 1'b0;
    if (seen) model_q.push_back(data);
    step();
  endtask

  task automatic pop_flit();
    logic [DW-1:0] exp;
    exp = (model_q.size() > 0) ? model_q.pop_front() : '0;
    check("head", bus.Data_out, exp);
    bus.read_en_L = 1'b1;
    step();
    bus.read_en_L = 1'b0;
  endtask

  initial begin
    logic cts_any;
    bus.RX = '0; bus.DRTS = 1'b0;
    bus.read_en_N = 1'b0; bus.read_en_E = 1'b0; bus.read_en_W = 1'b0;
    bus.read_en_S = 1'b0; bus.read_en_L = 1'b0;

    // T1 reset with DRTS held high
    rst = 1'b1; bus.DRTS = 1'b1; bus.RX = 32'hDEAD_BEEF;
    step(); step();
    check("rst_cts", bus.CTS, 1'b0);
    check("rst_empty", bus.empty, 1'b1);
    check("rst_full", bus.full, 1'b0);
    check("rst_count", bus.count, 0);
    check("rst_data", bus.Data_out, 0);
    check("rst_err", bus.err_flags, 2'b00);
    bus.DRTS = 1'b0;
    rst = 1'b0;
    step();

    // T2 single flit
    bus.DRTS = 1'b1; bus.RX = 32'hA5A5_0001;
    step();
    check("t2_cts_hi", bus.CTS, 1'b1);
    check("t2_count", bus.count, 1);
    check("t2_empty", bus.empty, 1'b0);
    check("t2_data", bus.Data_out, 32'hA5A5_0001);
    bus.DRTS = 1'b0;
    step();
    check("t2_cts_lo", bus.CTS, 1'b0);
    bus.read_en_L = 1'b1;
    step();
    bus.read_en_L = 1'b0;
    check("t2_empty_after", bus.empty, 1'b1);
    check("t2_count_after", bus.count, 0);

    // T3 fill to DEPTH, fifth offer held off until a pop
    for (int i = 1; i <= 4; i++) send_flit(32'h3000_0000 + i);
    check("t3_full", bus.full, 1'b1);
    check("t3_count", bus.count, 4);
    bus.DRTS = 1'b1; bus.RX = 32'h3000_0005;
    cts_any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      cts_any |= bus.CTS;
    end
    check("t3_no_cts_full", cts_any, 1'b0);
    check("t3_head", bus.Data_out, 32'h3000_0001);
    bus.read_en_N = 1'b1;
    step();
    bus.read_en_N = 1'b0;
    void'(model_q.pop_front());
    check("t3_cts_pop_edge", bus.CTS, 1'b0);
    check("t3_count_pop", bus.count, 3);
    step();
    check("t3_cts_5th", bus.CTS, 1'b1);
    check("t3_count_5th", bus.count, 4);
    model_q.push_back(32'h3000_0005);
    bus.DRTS = 1'b0;
    step();
    for (int i = 0; i < 4; i++) pop_flit();
    check("t3_drained", bus.empty, 1'b1);

    // T4 wrap: ten writes, pop whenever two flits are queued
    for (int i = 0; i < 10; i++) begin
      send_flit(32'h4400_0000 + i);
      if (bus.count == 2) pop_flit();
    end
    while (model_q.size() > 0) pop_flit();
    check("t4_count_end", bus.count, 0);
    check("t4_empty_end", bus.empty, 1'b1);

    // T5 simultaneous write and pop at count=2
    send_flit(32'h5500_000A);
    send_flit(32'h5500_000B);
    check("t5_count2", bus.count, 2);
    check("t5_head_a", bus.Data_out, 32'h5500_000A);
    bus.DRTS = 1'b1; bus.RX = 32'h5500_000C; bus.read_en_E = 1'b1;
    step();
    bus.DRTS = 1'b0; bus.read_en_E = 1'b0;
    void'(model_q.pop_front());
    model_q.push_back(32'h5500_000C);
    check("t5_cts", bus.CTS, 1'b1);
    check("t5_count_same", bus.count, 2);
    check("t5_head_b", bus.Data_out, 32'h5500_000B);
    step();
    pop_flit();
    pop_flit();
    check("t5_empty", bus.empty, 1'b1);

    // T6 protocol errors
    check("t6_err_clean", bus.err_flags, 2'b00);
    bus.read_en_S = 1'b1;
    step();
    bus.read_en_S = 1'b0;
    check("t6_err_empty", bus.err_flags, ERR_EMPTY);
    check("t6_count_ignored", bus.count, 0);
    send_flit(32'h6600_0001);
    bus.read_en_N = 1'b1; bus.read_en_W = 1'b1;
    step();
    bus.read_en_N = 1'b0; bus.read_en_W = 1'b0;
    void'(model_q.pop_front());
    check("t6_err_multi", bus.err_flags, ERR_BOTH);
    check("t6_one_pop", bus.count, 0);
    step();
    check("t6_err_sticky", bus.err_flags, ERR_BOTH);

    // Reset mid-transfer drops stored flits and in-flight CTS
    send_flit(32'h7700_0001);
    bus.DRTS = 1'b1; bus.RX = 32'h7700_0002;
    step();
    check("t7_cts_pre", bus.CTS, 1'b1);
    rst = 1'b1; bus.DRTS = 1'b0;
    step();
    rst = 1'b0;
    model_q.delete();
    check("t7_cts_rst", bus.CTS, 1'b0);
    check("t7_count_rst", bus.count, 0);
    check("t7_data_rst", bus.Data_out, 0);
    check("t7_err_rst", bus.err_flags, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
